// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with single-cycle special cases.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [4:0]      ALU_OPCODE,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [2:0]          op_r;
  logic                neg_r;
  logic [XLEN-1:0]     mag1_r;
  logic [XLEN-1:0]     mag2_r;
  logic [XLEN-1:0]     rem_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [CW-1:0]       cnt_r;
  logic                out_valid_r;
  logic [XLEN-1:0]     result_r;

  logic                is_m_s;
  logic                is_div_s;
  logic                signed1_s;
  logic                signed2_s;
  logic                neg1_s;
  logic                neg2_s;
  logic [XLEN-1:0]     mag1_s;
  logic [XLEN-1:0]     mag2_s;
  logic                neg_s;
  logic                div0_s;
  logic                ovf_s;
  logic                fast_s;
  logic [XLEN-1:0]     fast_res_s;

  logic [XLEN:0]       mul_sum_s;
  logic [2*XLEN-1:0]   mul_next_s;
  logic [XLEN:0]       div_shift_s;
  logic [XLEN:0]       div_trial_s;
  logic                div_ge_s;
  logic [XLEN-1:0]     rem_next_s;
  logic [XLEN-1:0]     quo_next_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_fix_s;
  logic [XLEN-1:0]     rem_fix_s;
  logic [XLEN-1:0]     calc_res_s;

  assign IN_READY  = (state_r == IDLE);
  assign BUSY      = (state_r != IDLE);
  assign OUT_VALID = out_valid_r;
  assign RESULT    = result_r;

  // Accept-time decode: operand magnitudes, result sign and special cases.
  always_comb begin
    is_m_s   = (ALU_OPCODE[4:3] == 2'b01);
    is_div_s = is_m_s && ALU_OPCODE[2];
    case (ALU_OPCODE[2:0])
      3'b000, 3'b001, 3'b100, 3'b110: begin
        signed1_s = 1'b1;
        signed2_s = 1'b1;
      end
      3'b011: begin
        signed1_s = 1'b1;
        signed2_s = 1'b0;
      end
      default: begin
        signed1_s = 1'b0;
        signed2_s = 1'b0;
      end
    endcase
    neg1_s = signed1_s && DATA1[XLEN-1];
    neg2_s = signed2_s && DATA2[XLEN-1];
    mag1_s = neg1_s ? -DATA1 : DATA1;
    mag2_s = neg2_s ? -DATA2 : DATA2;
    // Remainders follow the dividend; everything else follows sign1 ^ sign2.
    if (ALU_OPCODE[2:1] == 2'b11) begin
      neg_s = neg1_s;
    end else begin
      neg_s = neg1_s ^ neg2_s;
    end
    div0_s = is_div_s && (DATA2 == {XLEN{1'b0}});
    ovf_s  = is_div_s && !ALU_OPCODE[0] &&
             (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == {XLEN{1'b1}});
    fast_s = !is_m_s || div0_s || ovf_s;
    if (div0_s) begin
      fast_res_s = ALU_OPCODE[1] ? DATA1 : {XLEN{1'b1}};
    end else if (ovf_s) begin
      fast_res_s = ALU_OPCODE[1] ? {XLEN{1'b0}} : DATA1;
    end else begin
      fast_res_s = {XLEN{1'b0}};
    end
  end

  // One iteration step for both datapaths plus the final sign fix and selection.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                  (acc_r[0] ? {1'b0, mag1_r} : {(XLEN+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};
    div_shift_s = {rem_r, acc_r[XLEN-1]};
    div_trial_s = div_shift_s - {1'b0, mag2_r};
    div_ge_s    = !div_trial_s[XLEN];
    rem_next_s  = div_ge_s ? div_trial_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
    quo_next_s  = {acc_r[XLEN-2:0], div_ge_s};
    prod_s      = neg_r ? -mul_next_s : mul_next_s;
    quo_fix_s   = neg_r ? -quo_next_s : quo_next_s;
    rem_fix_s   = neg_r ? -rem_next_s : rem_next_s;
    case (op_r)
      3'b000:                 calc_res_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_res_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_res_s = quo_fix_s;
      default:                calc_res_s = rem_fix_s;
    endcase
  end

  // Control FSM and datapath registers; RESET beats FLUSH beats handshake.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= IDLE;
      op_r        <= 3'd0;
      neg_r       <= 1'b0;
      mag1_r      <= {XLEN{1'b0}};
      mag2_r      <= {XLEN{1'b0}};
      rem_r       <= {XLEN{1'b0}};
      acc_r       <= {(2*XLEN){1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
    end else if (FLUSH) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (IN_VALID) begin
            op_r   <= ALU_OPCODE[2:0];
            neg_r  <= neg_s;
            mag1_r <= mag1_s;
            mag2_r <= mag2_s;
            rem_r  <= {XLEN{1'b0}};
            acc_r  <= {{XLEN{1'b0}}, (is_div_s ? mag1_s : mag2_s)};
            cnt_r  <= {CW{1'b0}};
            if (fast_s) begin
              result_r    <= fast_res_s;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          acc_r <= op_r[2] ? {{XLEN{1'b0}}, quo_next_s} : mul_next_s;
          rem_r <= rem_next_s;
          if (cnt_r == LAST_ITER) begin
            result_r    <= calc_res_s;
            out_valid_r <= 1'b1;
            cnt_r       <= {CW{1'b0}};
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, handshake/flush/reset
// scenarios and randomized operations against a 64-bit arithmetic reference.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            FLUSH;
  logic            IN_VALID;
  logic            IN_READY;
  logic [4:0]      ALU_OPCODE;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] RESULT;
  logic            BUSY;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .ALU_OPCODE(ALU_OPCODE), .DATA1(DATA1),
    .DATA2(DATA2), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .BUSY(BUSY)
  );

  // Reference: RV32M semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, ua, ub, p;
    longint unsigned pu;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'b01000: begin p = sa * sb; return p[31:0]; end
      5'b01001: begin p = sa * sb; return p[63:32]; end
      5'b01010: begin pu = 64'(ua) * 64'(ub); return pu[63:32]; end
      5'b01011: begin p = sa * ub; return p[63:32]; end
      5'b01100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      5'b01101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      5'b01110: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      5'b01111: begin
        if (b == 32'd0) return a;
        return a % b;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[4:3] != 2'b01) return 1;
    if (op[2] && b == 32'd0) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one operation, then wait (bounded) for OUT_VALID; latency counts the accept edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    ALU_OPCODE = op;
    DATA1      = a;
    DATA2      = b;
    IN_VALID   = 1'b1;
    tick();
    IN_VALID = 1'b0;
    lat      = 1;
    while (!OUT_VALID && lat < 100) begin
      tick();
      lat++;
    end
    res = RESULT;
  endtask

  task automatic consume();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int          lat;
    issue(op, a, b, res, lat);
    check({tag, " out_valid"}, {31'd0, OUT_VALID}, 32'd1);
    check(tag, res, exp);
    check({tag, " latency"}, lat, exp_lat);
    consume();
    check({tag, " in_ready after consume"}, {31'd0, IN_READY}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"}, {31'd0, IN_READY}, 32'd1);
    check({tag, " out_valid"}, {31'd0, OUT_VALID}, 32'd0);
    check({tag, " busy"}, {31'd0, BUSY}, 32'd0);
    check({tag, " result"}, RESULT, 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    int          lat;
    int          seen;

    RESET      = 1'b1;
    FLUSH      = 1'b0;
    IN_VALID   = 1'b0;
    OUT_READY  = 1'b0;
    ALU_OPCODE = 5'd0;
    DATA1      = 32'd0;
    DATA2      = 32'd0;
    repeat (2) tick();
    check_reset_outputs("reset");
    RESET = 1'b0;
    tick();

    do_op("MUL 10x20", 5'b01000, 32'd10, 32'd20, 32'd200, 33);
    do_op("MULH -1x-1", 5'b01001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33);
    do_op("MULHU", 5'b01010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("MULHSU", 5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    do_op("DIV -7/2", 5'b01100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("REM -7/2", 5'b01110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("DIVU 20/10", 5'b01101, 32'd20, 32'd10, 32'd2, 33);
    do_op("REMU 20/10", 5'b01111, 32'd20, 32'd10, 32'd0, 33);
    do_op("DIV 5/0", 5'b01100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("REMU 5/0", 5'b01111, 32'd5, 32'd0, 32'd5, 1);
    do_op("DIV ovf", 5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("REM ovf", 5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    do_op("illegal op", 5'b11111, 32'd123, 32'd456, 32'd0, 1);

    // Backpressure: result and handshake frozen while OUT_READY is low.
    issue(5'b01000, 32'd7, 32'd9, res, lat);
    check("bp result", res, 32'd63);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp result stable", RESULT, 32'd63);
      check("bp out_valid held", {31'd0, OUT_VALID}, 32'd1);
      check("bp in_ready low", {31'd0, IN_READY}, 32'd0);
      check("bp busy", {31'd0, BUSY}, 32'd1);
    end
    consume();
    check("bp in_ready after consume", {31'd0, IN_READY}, 32'd1);

    // Flush during iteration 5 of a multiply.
    ALU_OPCODE = 5'b01000;
    DATA1      = 32'd1000;
    DATA2      = 32'd1000;
    IN_VALID   = 1'b1;
    tick();
    IN_VALID = 1'b0;
    repeat (5) tick();
    check("flush busy before", {31'd0, BUSY}, 32'd1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check_reset_outputs("flush calc");
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (OUT_VALID) seen++;
    end
    check("flush no stale out_valid", seen, 32'd0);
    do_op("MUL 3x4 after flush", 5'b01000, 32'd3, 32'd4, 32'd12, 33);

    // FLUSH with IN_VALID in IDLE must not accept.
    ALU_OPCODE = 5'b01000;
    DATA1      = 32'd5;
    DATA2      = 32'd6;
    IN_VALID   = 1'b1;
    FLUSH      = 1'b1;
    tick();
    IN_VALID = 1'b0;
    FLUSH    = 1'b0;
    check("flush idle busy", {31'd0, BUSY}, 32'd1 - 32'd1);
    check("flush idle in_ready", {31'd0, IN_READY}, 32'd1);
    repeat (35) tick();
    check("flush idle no result", {31'd0, OUT_VALID}, 32'd0);

    // Reset mid-CALC.
    ALU_OPCODE = 5'b01101;
    DATA1      = 32'd100;
    DATA2      = 32'd7;
    IN_VALID   = 1'b1;
    tick();
    IN_VALID = 1'b0;
    repeat (10) tick();
    RESET = 1'b1;
    tick();
    check_reset_outputs("reset calc");
    RESET = 1'b0;
    do_op("DIVU 100/7 after reset", 5'b01101, 32'd100, 32'd7, 32'd14, 33);

    // Reset while holding a result in DONE.
    issue(5'b01000, 32'd6, 32'd7, res, lat);
    check("pre-reset done result", res, 32'd42);
    RESET = 1'b1;
    tick();
    check_reset_outputs("reset done");
    RESET = 1'b0;
    do_op("DIVU 100/7 after done reset", 5'b01101, 32'd100, 32'd7, 32'd14, 33);

    // Randomized operations with corner-biased operands and random backpressure.
    for (int i = 0; i < 40; i++) begin
      op = 5'b01000 | 5'($urandom_range(0, 7));
      if (i % 10 == 9) op = 5'($urandom);
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: a = 32'($urandom_range(0, 50));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 50));
        default: b = $urandom;
      endcase
      issue(op, a, b, res, lat);
      check($sformatf("rand%0d op=%b a=%h b=%h", i, op, a, b), res, model(op, a, b));
      check($sformatf("rand%0d latency", i), lat, model_lat(op, a, b));
      held = model(op, a, b);
      repeat ($urandom_range(0, 3)) begin
        tick();
        check($sformatf("rand%0d held", i), RESULT, held);
      end
      consume();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
